// File: rtl/wca_ddc_strobe_controller_if.sv
// Bus interface for the DDC strobe controller.
//   master : drives run enable, sample strobe, config byte, rate/frequency writes
//   slave  : drives decimated/baseband strobes, CORDIC phase, committed rate, status
interface wca_ddc_strobe_controller_if #(
   parameter int PHASE_WIDTH = 32
);
   logic                   enable;
   logic                   strobe_adc;
   logic [7:0]             cfg;
   logic [9:0]             rate_decim;
   logic                   rate_we;
   logic [PHASE_WIDTH-1:0] freq_word;
   logic                   freq_we;
   logic                   strobe_cic;
   logic                   strobe_bb;
   logic [PHASE_WIDTH-1:0] phase_cordic;
   logic [9:0]             rate_active;
   logic [3:0]             log2_rate;
   logic                   running;

   modport master (
      output enable, strobe_adc, cfg, rate_decim, rate_we, freq_word, freq_we,
      input  strobe_cic, strobe_bb, phase_cordic, rate_active, log2_rate, running
   );

   modport slave (
      input  enable, strobe_adc, cfg, rate_decim, rate_we, freq_word, freq_we,
      output strobe_cic, strobe_bb, phase_cordic, rate_active, log2_rate, running
   );
endinterface

// File: rtl/wca_ddc_strobe_controller.sv
// DDC strobe controller: derives the CIC decimation strobe, the baseband strobe
// and the CORDIC down-conversion phase from the ADC sample strobe.
//   clock, reset : system clock, async active-low reset
//   bus (slave)  : enable, strobe_adc, cfg, rate_decim/rate_we, freq_word/freq_we in;
//                  strobe_cic, strobe_bb, phase_cordic, rate_active, log2_rate, running out
// cfg bits: [1] clear, [2] CORDIC bypass, [4] CIC strobe bypass, [5] half-band bypass.
module wca_ddc_strobe_controller #(
   parameter int DEFAULT_RATE = 4,
   parameter int PRIME_COUNT  = 2,
   parameter int PHASE_WIDTH  = 32
) (
   input logic                        clock,
   input logic                        reset,
   wca_ddc_strobe_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

   // Index of the highest set bit; 0 and 1 both map to 0.
   function automatic logic [3:0] flog2(input logic [9:0] v);
      flog2 = 4'd0;
      for (int i = 1; i < 10; i++)
         if (v[i]) flog2 = 4'(i);
   endfunction

   state_t                 state, state_nxt;
   logic [9:0]             cnt;
   logic [3:0]             prime_cnt;
   logic                   bb_tog;
   logic [9:0]             rate_act, rate_pend;
   logic                   pend_flag;
   logic [3:0]             log2_r;
   logic [PHASE_WIDTH-1:0] phase, inc;
   logic                   cic_r, bb_r;

   logic                   go_idle, act, boundary, qual, emit;
   logic                   in_prime, in_run, prime_done;
   logic [9:0]             r_eff;
   logic                   unused_cfg;

   assign unused_cfg = ^{bus.cfg[7:6], bus.cfg[3], bus.cfg[0]};

   assign go_idle  = !bus.enable || bus.cfg[1];
   // Counting happens only in PRIME/RUN and not on the edge that drops to IDLE.
   assign act      = (state != IDLE) && !go_idle;
   assign r_eff    = (rate_act == 10'd0) ? 10'd1 : rate_act;
   assign boundary = act && bus.strobe_adc && (cnt >= r_eff - 10'd1);
   assign qual     = act && bus.strobe_adc && (bus.cfg[4] || boundary);
   assign emit     = qual && in_run;
   // A suppressed pulse in PRIME that brings the count to PRIME_COUNT moves to RUN.
   assign prime_done = qual && (({1'b0, prime_cnt} + 5'd1) >= 5'(PRIME_COUNT));

   // ---- FSM: state register ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      if (go_idle) state_nxt = IDLE;
      else begin
         case (state)
            IDLE:    state_nxt = (PRIME_COUNT == 0) ? RUN : PRIME;
            PRIME:   if (prime_done) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---- FSM: outputs ----
   always_comb begin
      in_prime = 1'b0;
      in_run   = 1'b0;
      case (state)
         PRIME:   in_prime = 1'b1;
         RUN:     in_run   = 1'b1;
         default: ;
      endcase
   end

   // ---- counters, strobes, bb toggle ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         prime_cnt <= '0;
         bb_tog    <= 1'b0;
         cic_r     <= 1'b0;
         bb_r      <= 1'b0;
      end else begin
         cic_r <= emit;
         bb_r  <= emit && (bus.cfg[5] || bb_tog);
         if (!act) begin
            cnt       <= '0;
            prime_cnt <= '0;
            bb_tog    <= 1'b0;
         end else begin
            if (bus.strobe_adc) cnt <= boundary ? 10'd0 : cnt + 10'd1;
            if (qual && in_prime) prime_cnt <= prime_cnt + 4'd1;
            if (emit) bb_tog <= ~bb_tog;
         end
      end
   end

   // ---- rate pending/commit ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rate_act  <= 10'(DEFAULT_RATE);
         rate_pend <= 10'(DEFAULT_RATE);
         pend_flag <= 1'b0;
         log2_r    <= flog2(10'(DEFAULT_RATE));
      end else if (bus.rate_we && boundary) begin
         // A write landing on a boundary bypasses the pending stage.
         rate_act  <= bus.rate_decim;
         rate_pend <= bus.rate_decim;
         pend_flag <= 1'b0;
         log2_r    <= flog2(bus.rate_decim);
      end else if (bus.rate_we) begin
         rate_pend <= bus.rate_decim;
         pend_flag <= 1'b1;
      end else if (pend_flag && (state == IDLE || boundary)) begin
         rate_act  <= rate_pend;
         pend_flag <= 1'b0;
         log2_r    <= flog2(rate_pend);
      end
   end

   // ---- phase accumulator ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase <= '0;
         inc   <= '0;
      end else begin
         if (bus.freq_we) inc <= bus.freq_word;
         if (!act || bus.cfg[2]) phase <= '0;
         else if (bus.strobe_adc) phase <= phase + inc;
      end
   end

   assign bus.strobe_cic   = cic_r;
   assign bus.strobe_bb    = bb_r;
   assign bus.phase_cordic = phase;
   assign bus.rate_active  = rate_act;
   assign bus.log2_rate    = log2_r;
   assign bus.running      = in_run;

endmodule

// File: tb/tb_wca_ddc_strobe_controller.sv
// Bench for wca_ddc_strobe_controller: directed phases plus a randomized phase,
// compared every clock against a strobe-counting reference model.
module tb_wca_ddc_strobe_controller;
   localparam int PRIME = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   ncic  = 0;
   int   nbb   = 0;

   wca_ddc_strobe_controller_if #(.PHASE_WIDTH(32)) bus ();

   wca_ddc_strobe_controller #(.DEFAULT_RATE(4), .PRIME_COUNT(PRIME), .PHASE_WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // ---- reference model: counts strobes since the last window start and
   //      qualifying events since leaving idle ----
   bit          live;
   int          nq, since;
   logic [9:0]  mrate, mpend;
   bit          mpf;
   logic [31:0] mphase, minc;
   bit          e_cic, e_bb;

   function automatic int exp_log2(input int v);
      return (v <= 1) ? 0 : $clog2(v + 1) - 1;
   endfunction

   task automatic model_reset();
      live = 0; nq = 0; since = 0;
      mrate = 10'd4; mpend = 10'd4; mpf = 0;
      mphase = 0; minc = 0; e_cic = 0; e_bb = 0;
   endtask

   task automatic model_step();
      bit go_idle, act, bnd, qual;
      int r;
      go_idle = !bus.enable || bus.cfg[1];
      act     = live && !go_idle;
      r       = (mrate == 0) ? 1 : int'(mrate);
      bnd     = act && bus.strobe_adc && (since + 1 >= r);
      qual    = act && bus.strobe_adc && (bus.cfg[4] || bnd);
      e_cic   = qual && (nq >= PRIME);
      e_bb    = e_cic && (bus.cfg[5] || ((nq - PRIME + 1) % 2 == 0));
      if (bus.rate_we && bnd) begin
         mrate = bus.rate_decim; mpend = bus.rate_decim; mpf = 0;
      end else if (bus.rate_we) begin
         mpend = bus.rate_decim; mpf = 1;
      end else if (mpf && (!live || bnd)) begin
         mrate = mpend; mpf = 0;
      end
      if (!act || bus.cfg[2]) mphase = 0;
      else if (bus.strobe_adc) mphase = mphase + minc;
      if (bus.freq_we) minc = bus.freq_word;
      if (!act) begin
         since = 0; nq = 0;
      end else begin
         if (bus.strobe_adc) since = bnd ? 0 : since + 1;
         if (qual) nq++;
      end
      live = !go_idle;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("strobe_cic", 32'(bus.strobe_cic), 32'(e_cic));
      chk("strobe_bb", 32'(bus.strobe_bb), 32'(e_bb));
      chk("phase_cordic", bus.phase_cordic, mphase);
      chk("rate_active", 32'(bus.rate_active), 32'(mrate));
      chk("log2_rate", 32'(bus.log2_rate), 32'(exp_log2(int'(mrate))));
      chk("running", 32'(bus.running), 32'(live && nq >= PRIME));
   endtask

   task automatic cyc();
      if (reset) model_step(); else model_reset();
      @(posedge clock); #1;
      check_all();
      if (bus.strobe_cic) ncic++;
      if (bus.strobe_bb)  nbb++;
      bus.strobe_adc = 0; bus.rate_we = 0; bus.freq_we = 0;
   endtask

   // n strobes, each preceded by gap idle clocks (gap < 0: random 0..2)
   task automatic strobes(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat ((gap < 0) ? int'($urandom_range(0, 2)) : gap) cyc();
         bus.strobe_adc = 1;
         cyc();
      end
   endtask

   initial begin
      bus.enable = 0; bus.strobe_adc = 0; bus.cfg = 8'h00;
      bus.rate_decim = 0; bus.rate_we = 0; bus.freq_word = 0; bus.freq_we = 0;
      model_reset();
      #12;
      check_all();
      reset = 1;
      cyc(); cyc();

      // R=4, prime 2, strobe every 3 clocks: pulses at strobes 12 and 16
      bus.enable = 1;
      cyc();
      ncic = 0; nbb = 0;
      strobes(16, 2);
      cyc();
      chk("prime_cic_count", 32'(ncic), 32'd2);
      chk("prime_bb_count", 32'(nbb), 32'd1);
      strobes(12, 2);

      // bypass both: cic/bb follow strobe_adc; rate 8 commits on a boundary
      bus.cfg = 8'h30;
      bus.rate_decim = 10'd8; bus.rate_we = 1; cyc();
      strobes(30, -1);
      bus.rate_decim = 10'd3; bus.rate_we = 1; cyc();
      strobes(20, -1);
      bus.rate_decim = 10'd8; bus.rate_we = 1; cyc();
      strobes(10, 1);

      // R=8 mid-window change to 5
      bus.cfg = 8'h00;
      strobes(3, 1);
      bus.rate_decim = 10'd5; bus.rate_we = 1; cyc();
      chk("hold_rate8", 32'(bus.rate_active), 32'd8);
      strobes(24, -1);

      // rate 4, then write 16 exactly on a boundary
      bus.rate_decim = 10'd4; bus.rate_we = 1; cyc();
      strobes(10, 0);
      begin
         bit done = 0;
         for (int i = 0; i < 12 && !done; i++) begin
            if (since + 1 >= int'(mrate)) begin
               bus.rate_we = 1; bus.rate_decim = 10'd16; done = 1;
            end
            bus.strobe_adc = 1;
            cyc();
         end
         chk("coincident_seen", 32'(done), 32'd1);
         chk("coincident_rate", 32'(bus.rate_active), 32'd16);
      end
      strobes(34, -1);
      bus.rate_decim = 10'd0; bus.rate_we = 1; cyc();
      strobes(20, -1);

      // phase accumulation, bypass, clear pulse
      bus.freq_word = 32'h4000_0000; bus.freq_we = 1; cyc();
      bus.strobe_adc = 1; cyc(); chk("phase1", bus.phase_cordic, 32'h4000_0000);
      bus.strobe_adc = 1; cyc(); chk("phase2", bus.phase_cordic, 32'h8000_0000);
      bus.strobe_adc = 1; cyc(); chk("phase3", bus.phase_cordic, 32'hC000_0000);
      bus.strobe_adc = 1; cyc(); chk("phase4", bus.phase_cordic, 32'h0000_0000);
      bus.cfg = 8'h04;
      strobes(3, 0);
      bus.cfg = 8'h00;
      strobes(3, 1);
      bus.cfg = 8'h02; cyc();
      chk("clear_running", 32'(bus.running), 32'd0);
      bus.cfg = 8'h00;
      bus.rate_decim = 10'd3; bus.rate_we = 1; cyc();
      strobes(12, 1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         bus.strobe_adc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) begin
            bus.rate_we = 1; bus.rate_decim = 10'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 19) == 0) begin
            bus.freq_we = 1; bus.freq_word = $urandom;
         end
         if ($urandom_range(0, 29) == 0)
            bus.cfg = {2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), 1'b0};
         bus.enable = ($urandom_range(0, 99) != 0);
         cyc();
      end

      // async reset during RUN with a non-default rate
      bus.cfg = 8'h00; bus.enable = 1;
      bus.rate_decim = 10'd9; bus.rate_we = 1; cyc();
      strobes(30, 0);
      bus.freq_word = 32'h1234_5677; bus.freq_we = 1; cyc();
      strobes(2, 0);
      #3 reset = 0;
      #1;
      chk("rst_cic", 32'(bus.strobe_cic), 32'd0);
      chk("rst_bb", 32'(bus.strobe_bb), 32'd0);
      chk("rst_phase", bus.phase_cordic, 32'd0);
      chk("rst_running", 32'(bus.running), 32'd0);
      chk("rst_rate", 32'(bus.rate_active), 32'd4);
      chk("rst_log2", 32'(bus.log2_rate), 32'd2);
      model_reset();
      bus.strobe_adc = 1;
      cyc(); cyc();
      reset = 1;
      cyc(); cyc();
      chk("post_rst_rate", 32'(bus.rate_active), 32'd4);
      strobes(20, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
